// File: rtl/fp_addsubt_arbiter_pkg.sv
// Shared types for the FP add/subtract arbiter: FSM encoding, op codes, widths.
package fp_addsubt_arbiter_pkg;

    localparam int FP_W  = 32;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } fp_op_e;

endpackage

// File: rtl/fp_addsubt_arbiter_rr_pick.sv
// Round-robin pick: first pending requester at or after ptr, wrapping modulo N_REQ.
module fp_addsubt_arbiter_rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [1:0]       ptr,
    output logic [1:0]       grant,
    output logic             any_pending
);

    always_comb begin
        grant       = '0;
        any_pending = 1'b0;
        // k is the distance from ptr; the first hit in k order wins
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!any_pending && pending[j] &&
                    ((int'(ptr) + k == j) || (int'(ptr) + k == j + N_REQ))) begin
                    any_pending = 1'b1;
                    grant       = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fp_addsubt_arbiter.sv
// Shares one FP add/subtract unit between N_REQ CORDIC sequencers using their
// Begin/ACK pulse handshake; requests are latched and served round-robin.
module fp_addsubt_arbiter
    import fp_addsubt_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int W           = FP_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ_BEGIN,
    input  logic [N_REQ-1:0]   REQ_ADD_SUBT,
    input  logic [N_REQ*W-1:0] REQ_DATA_A,
    input  logic [N_REQ*W-1:0] REQ_DATA_B,
    output logic [N_REQ-1:0]   REQ_ACK,
    output logic [W-1:0]       RESULT,
    output logic               FPU_BEGIN,
    output logic               FPU_ADD_SUBT,
    output logic [W-1:0]       FPU_DATA_A,
    output logic [W-1:0]       FPU_DATA_B,
    input  logic               FPU_ACK,
    input  logic [W-1:0]       FPU_RESULT,
    output logic               BUSY,
    output logic [1:0]         GRANT_ID,
    output logic               ERR_OVERRUN,
    output logic               ERR_TIMEOUT
);

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

    arb_state_e                  state_q, state_d;
    logic [N_REQ-1:0]            pend_q, pend_d;
    logic [N_REQ-1:0][W-1:0]     a_q, a_d, b_q, b_d;
    logic [N_REQ-1:0]            op_q, op_d;
    logic [W-1:0]                fa_q, fa_d, fb_q, fb_d, res_q, res_d;
    fp_op_e                      fop_q, fop_d;
    logic [1:0]                  ptr_q, ptr_d, gid_q, gid_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_inc;
    logic                        ovr_q, ovr_d, tmo_q, tmo_d;
    logic [1:0]                  win;
    logic                        any;
    logic                        clr;

    assign cnt_inc = cnt_q + CNT_W'(1);

    fp_addsubt_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .pending     (pend_q),
        .ptr         (ptr_q),
        .grant       (win),
        .any_pending (any)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            fop_q   <= OP_ADD;
            res_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fop_q   <= fop_d;
            res_q   <= res_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (FPU_ACK || cnt_inc == TMO_LIMIT) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        fop_d  = fop_q;
        res_d  = res_q;
        ptr_d  = ptr_q;
        gid_d  = gid_q;
        cnt_d  = cnt_q;
        ovr_d  = ovr_q;
        tmo_d  = tmo_q;
        clr    = 1'b0;

        // The DONE clear and a fresh request on the same edge resolve as "set wins".
        for (int i = 0; i < N_REQ; i++) begin
            clr = (state_q == ST_DONE) && (gid_q == 2'(i));
            if (clr) pend_d[i] = 1'b0;
            if (REQ_BEGIN[i]) begin
                if (pend_q[i] && !clr) begin
                    ovr_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    a_d[i]    = REQ_DATA_A[i*W +: W];
                    b_d[i]    = REQ_DATA_B[i*W +: W];
                    op_d[i]   = REQ_ADD_SUBT[i];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    gid_d = win;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (win == 2'(i)) begin
                            fa_d  = a_q[i];
                            fb_d  = b_q[i];
                            fop_d = fp_op_e'(op_q[i]);
                        end
                    end
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (FPU_ACK) begin
                    res_d = FPU_RESULT;
                end else if (cnt_inc == TMO_LIMIT) begin
                    res_d = '0;
                    tmo_d = 1'b1;
                end
            end
            ST_DONE: ptr_d = (gid_q == 2'(N_REQ - 1)) ? 2'd0 : gid_q + 2'd1;
            default: ;
        endcase
    end

    always_comb begin
        FPU_BEGIN    = (state_q == ST_ISSUE);
        BUSY         = (state_q != ST_IDLE);
        FPU_ADD_SUBT = fop_q;
        FPU_DATA_A   = fa_q;
        FPU_DATA_B   = fb_q;
        RESULT       = res_q;
        GRANT_ID     = gid_q;
        ERR_OVERRUN  = ovr_q;
        ERR_TIMEOUT  = tmo_q;
        for (int i = 0; i < N_REQ; i++)
            REQ_ACK[i] = (state_q == ST_DONE) && (gid_q == 2'(i));
    end

endmodule

// File: tb/tb_fp_addsubt_arbiter.sv
// Bench for fp_addsubt_arbiter: toy FP unit model plus per-requester expected-result queues.
module tb_fp_addsubt_arbiter;

    localparam int TMO = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  REQ_BEGIN = '0, REQ_ADD_SUBT = '0;
    logic [63:0] REQ_DATA_A = '0, REQ_DATA_B = '0;
    logic [1:0]  REQ_ACK;
    logic [31:0] RESULT;
    logic        FPU_BEGIN, FPU_ADD_SUBT;
    logic [31:0] FPU_DATA_A, FPU_DATA_B;
    logic        FPU_ACK = 1'b0;
    logic [31:0] FPU_RESULT = '0;
    logic        BUSY;
    logic [1:0]  GRANT_ID;
    logic        ERR_OVERRUN, ERR_TIMEOUT;

    int checks = 0, errors = 0, cyc = 0;

    fp_addsubt_arbiter #(.N_REQ(2), .W(32), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RST(RST), .REQ_BEGIN(REQ_BEGIN), .REQ_ADD_SUBT(REQ_ADD_SUBT),
        .REQ_DATA_A(REQ_DATA_A), .REQ_DATA_B(REQ_DATA_B), .REQ_ACK(REQ_ACK), .RESULT(RESULT),
        .FPU_BEGIN(FPU_BEGIN), .FPU_ADD_SUBT(FPU_ADD_SUBT), .FPU_DATA_A(FPU_DATA_A),
        .FPU_DATA_B(FPU_DATA_B), .FPU_ACK(FPU_ACK), .FPU_RESULT(FPU_RESULT), .BUSY(BUSY),
        .GRANT_ID(GRANT_ID), .ERR_OVERRUN(ERR_OVERRUN), .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Toy FP unit: 1.0+2.0 gives 3.0, anything else a fixed scramble of the operands.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return (a * 32'd3) ^ {b[30:0], 1'b0} ^ {31'b0, op} ^ 32'h5A5A0000;
    endfunction

    int          ack_cnt = 0, fpu_lat = 5;
    bit          fpu_respond = 1, rand_lat = 0, spurious = 0;
    logic [31:0] ack_res;

    always begin
        @(posedge CLK); #2;
        FPU_ACK = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin FPU_ACK = 1'b1; FPU_RESULT = ack_res; end
        end
        if (FPU_BEGIN && fpu_respond) begin
            ack_cnt = rand_lat ? $urandom_range(1, 8) : fpu_lat;
            ack_res = fpu_fn(FPU_DATA_A, FPU_DATA_B, FPU_ADD_SUBT);
        end else if (spurious && ack_cnt == 0 && !FPU_ACK && $urandom_range(0, 5) == 0) begin
            FPU_ACK = 1'b1; FPU_RESULT = $urandom;
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
        cyc++;
        REQ_BEGIN    = '0;
        REQ_DATA_A   = {$urandom, $urandom};
        REQ_DATA_B   = {$urandom, $urandom};
        REQ_ADD_SUBT = 2'($urandom);
    endtask

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
        REQ_BEGIN[i]           = 1'b1;
        REQ_DATA_A[i*32 +: 32] = a;
        REQ_DATA_B[i*32 +: 32] = b;
        REQ_ADD_SUBT[i]        = op;
    endtask

    task automatic do_reset();
        RST = 1'b1; ack_cnt = 0; spurious = 0; fpu_respond = 1; rand_lat = 0;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output bit got);
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            if (REQ_ACK != 2'b00) got = 1; else tick();
        end
    endtask

    task automatic wait_begin(input int budget, output bit got);
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            if (FPU_BEGIN) got = 1; else tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({REQ_ACK, RESULT, FPU_BEGIN, FPU_ADD_SUBT, FPU_DATA_A, FPU_DATA_B, BUSY, GRANT_ID,
             ERR_OVERRUN, ERR_TIMEOUT} !== '0) begin
            errors++; $display("FAIL reset_outputs: got ack=%b res=%h beg=%b busy=%b gid=%0d want all 0",
                REQ_ACK, RESULT, FPU_BEGIN, BUSY, GRANT_ID);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0 || FPU_BEGIN !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got busy=%b beg=%b want 0 0", BUSY, FPU_BEGIN);
        end
    endtask

    task automatic test_single();
        bit got; int bc;
        do_reset(); fpu_lat = 5;
        send(0, 32'h3F800000, 32'h40000000, 1'b0);
        tick();
        checks++;
        if (FPU_BEGIN !== 1'b0) begin errors++; $display("FAIL single_early_begin: got %b want 0", FPU_BEGIN); end
        tick();
        bc = cyc;
        checks++;
        if (FPU_BEGIN !== 1'b1 || GRANT_ID !== 2'd0) begin
            errors++; $display("FAIL single_begin_c2: got beg=%b gid=%0d want 1 0", FPU_BEGIN, GRANT_ID);
        end
        checks++;
        if ({FPU_DATA_A, FPU_DATA_B, FPU_ADD_SUBT} !== {32'h3F800000, 32'h40000000, 1'b0}) begin
            errors++; $display("FAIL single_operands: got %h %h %b want 3f800000 40000000 0",
                FPU_DATA_A, FPU_DATA_B, FPU_ADD_SUBT);
        end
        tick();
        checks++;
        if (FPU_BEGIN !== 1'b0) begin errors++; $display("FAIL single_begin_width: got %b want 0", FPU_BEGIN); end
        wait_ack(50, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL single_ack_wait: got no REQ_ACK want one");
        end else begin
            checks++;
            if (REQ_ACK !== 2'b01 || cyc != bc + 6) begin
                errors++; $display("FAIL single_ack: got ack=%b at +%0d want 01 at +6", REQ_ACK, cyc - bc);
            end
            checks++;
            if (RESULT !== 32'h40400000) begin
                errors++; $display("FAIL single_result: got %h want 40400000", RESULT);
            end
            tick();
            checks++;
            if (REQ_ACK !== 2'b00 || RESULT !== 32'h40400000 || BUSY !== 1'b0) begin
                errors++; $display("FAIL single_after: got ack=%b res=%h busy=%b want 00 40400000 0",
                    REQ_ACK, RESULT, BUSY);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit got; int d;
        logic [31:0] a0, b0, a1, b1;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        do_reset(); fpu_lat = 3;
        send(0, a0, b0, 1'b0);
        send(1, a1, b1, 1'b1);
        tick();
        wait_ack(50, got);
        checks++;
        if (!got || REQ_ACK !== 2'b01 || RESULT !== fpu_fn(a0, b0, 1'b0)) begin
            errors++; $display("FAIL simul_first: got ack=%b res=%h want 01 %h", REQ_ACK, RESULT, fpu_fn(a0, b0, 1'b0));
        end
        d = cyc;
        tick();
        wait_begin(10, got);
        checks++;
        if (!got || cyc != d + 2 || GRANT_ID !== 2'd1) begin
            errors++; $display("FAIL simul_second_begin: got +%0d gid=%0d want +2 1", cyc - d, GRANT_ID);
        end
        checks++;
        if ({FPU_DATA_A, FPU_DATA_B, FPU_ADD_SUBT} !== {a1, b1, 1'b1}) begin
            errors++; $display("FAIL simul_second_ops: got %h %h %b want %h %h 1",
                FPU_DATA_A, FPU_DATA_B, FPU_ADD_SUBT, a1, b1);
        end
        wait_ack(50, got);
        checks++;
        if (!got || REQ_ACK !== 2'b10 || RESULT !== fpu_fn(a1, b1, 1'b1)) begin
            errors++; $display("FAIL simul_second: got ack=%b res=%h want 10 %h", REQ_ACK, RESULT, fpu_fn(a1, b1, 1'b1));
        end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_q[2][$];
        logic [31:0] a, b;
        logic op;
        bit got; int id;
        do_reset(); rand_lat = 1;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom; op = 1'($urandom);
            send(i, a, b, op); exp_q[i].push_back(fpu_fn(a, b, op));
        end
        tick();
        for (int n = 0; n < 20; n++) begin
            wait_ack(60, got);
            checks++;
            if (!got) begin errors++; $display("FAIL fair_wait: op %0d got no ack want ack", n); break; end
            id = (REQ_ACK == 2'b01) ? 0 : (REQ_ACK == 2'b10) ? 1 : -1;
            checks++;
            if (id != n % 2) begin errors++; $display("FAIL fair_grant: op %0d got ack=%b want id %0d", n, REQ_ACK, n % 2); end
            if (id >= 0 && exp_q[id].size() > 0) begin
                checks++;
                if (RESULT !== exp_q[id][0]) begin
                    errors++; $display("FAIL fair_result: op %0d got %h want %h", n, RESULT, exp_q[id][0]);
                end
                void'(exp_q[id].pop_front());
                a = $urandom; b = $urandom; op = 1'($urandom);
                send(id, a, b, op); exp_q[id].push_back(fpu_fn(a, b, op));
            end
            tick();
        end
        checks++;
        if (ERR_OVERRUN !== 1'b0) begin errors++; $display("FAIL fair_no_overrun: got %b want 0", ERR_OVERRUN); end
    endtask

    task automatic test_overrun();
        logic [31:0] a1, b1;
        int acks = 0;
        bit first = 1;
        a1 = $urandom; b1 = $urandom;
        do_reset(); fpu_lat = 4;
        send(1, a1, b1, 1'b1);
        tick();
        send(1, ~a1, ~b1, 1'b0);
        tick();
        checks++;
        if (ERR_OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", ERR_OVERRUN); end
        checks++;
        if (FPU_BEGIN !== 1'b1 || {FPU_DATA_A, FPU_DATA_B, FPU_ADD_SUBT} !== {a1, b1, 1'b1}) begin
            errors++; $display("FAIL overrun_first_ops: got beg=%b %h %h %b want 1 %h %h 1",
                FPU_BEGIN, FPU_DATA_A, FPU_DATA_B, FPU_ADD_SUBT, a1, b1);
        end
        tick();
        send(1, $urandom, $urandom, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (REQ_ACK[1]) begin
                acks++;
                if (first) begin
                    first = 0;
                    checks++;
                    if (RESULT !== fpu_fn(a1, b1, 1'b1)) begin
                        errors++; $display("FAIL overrun_result: got %h want %h", RESULT, fpu_fn(a1, b1, 1'b1));
                    end
                end
            end
        end
        checks++;
        if (acks != 1) begin errors++; $display("FAIL overrun_ack_count: got %0d want 1", acks); end
    endtask

    task automatic test_reset_mid();
        bit got, late = 0;
        int bad = 0;
        fpu_lat = 6;
        send(0, $urandom, $urandom, 1'b1);
        tick();
        wait_begin(10, got);
        tick(); tick();
        checks++;
        if (!got || BUSY !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got busy=%b want 1", BUSY); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({REQ_ACK, RESULT, FPU_BEGIN, FPU_ADD_SUBT, FPU_DATA_A, FPU_DATA_B, BUSY, GRANT_ID,
             ERR_OVERRUN, ERR_TIMEOUT} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got res=%h busy=%b ovr=%b want all 0", RESULT, BUSY, ERR_OVERRUN);
        end
        for (int k = 0; k < 15; k++) begin
            tick();
            if (FPU_ACK) late = 1;
            if (REQ_ACK != 2'b00 || BUSY || FPU_BEGIN || RESULT != 32'h0) bad++;
        end
        checks++;
        if (!late || bad != 0) begin
            errors++; $display("FAIL rstmid_quiet: got late_ack=%b active_cycles=%0d want 1 0", late, bad);
        end
    endtask

    task automatic test_timeout();
        bit got; int bc;
        logic [31:0] a, b;
        do_reset(); fpu_lat = 3;
        send(0, 32'h12345678, 32'h0000ABCD, 1'b0);
        tick();
        wait_ack(50, got);
        checks++;
        if (!got || RESULT !== fpu_fn(32'h12345678, 32'h0000ABCD, 1'b0)) begin
            errors++; $display("FAIL tmo_pre_result: got %h want %h", RESULT, fpu_fn(32'h12345678, 32'h0000ABCD, 1'b0));
        end
        tick();
        fpu_respond = 0;
        send(1, $urandom, $urandom, 1'b1);
        tick();
        wait_begin(10, got);
        bc = cyc;
        tick();
        wait_ack(TMO + 20, got);
        checks++;
        if (!got || REQ_ACK !== 2'b10 || cyc != bc + TMO + 1) begin
            errors++; $display("FAIL tmo_ack_time: got ack=%b at +%0d want 10 at +%0d", REQ_ACK, cyc - bc, TMO + 1);
        end
        checks++;
        if (RESULT !== 32'h0 || ERR_TIMEOUT !== 1'b1) begin
            errors++; $display("FAIL tmo_result: got res=%h err=%b want 0 1", RESULT, ERR_TIMEOUT);
        end
        tick();
        fpu_respond = 1;
        a = $urandom; b = $urandom;
        send(0, a, b, 1'b1);
        tick();
        wait_ack(50, got);
        checks++;
        if (!got || REQ_ACK !== 2'b01 || RESULT !== fpu_fn(a, b, 1'b1) || ERR_TIMEOUT !== 1'b1) begin
            errors++; $display("FAIL tmo_recover: got ack=%b res=%h err=%b want 01 %h 1",
                REQ_ACK, RESULT, ERR_TIMEOUT, fpu_fn(a, b, 1'b1));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[2][$];
        logic [31:0] a, b;
        logic op;
        bit outst[2];
        int id, acks = 0;
        do_reset(); rand_lat = 1; spurious = 1;
        outst[0] = 0; outst[1] = 0;
        for (int t = 0; t < 900; t++) begin
            if (REQ_ACK != 2'b00) begin
                id = (REQ_ACK == 2'b01) ? 0 : (REQ_ACK == 2'b10) ? 1 : -1;
                checks++;
                if (id < 0 || !outst[id] || exp_q[id].size() == 0) begin
                    errors++; $display("FAIL rand_ack_valid: got ack=%b at cycle %0d want one outstanding", REQ_ACK, cyc);
                end else begin
                    checks++;
                    if (RESULT !== exp_q[id][0]) begin
                        errors++; $display("FAIL rand_result: req %0d got %h want %h", id, RESULT, exp_q[id][0]);
                    end
                    void'(exp_q[id].pop_front());
                    outst[id] = 0;
                    acks++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (t < 800 && !outst[i] && $urandom_range(0, 3) == 0) begin
                    a = $urandom; b = $urandom; op = 1'($urandom);
                    send(i, a, b, op); exp_q[i].push_back(fpu_fn(a, b, op));
                    outst[i] = 1;
                end
            end
            tick();
        end
        checks++;
        if (outst[0] || outst[1] || acks < 20) begin
            errors++; $display("FAIL rand_drain: got outstanding=%b%b acks=%0d want 00 and >=20", outst[1], outst[0], acks);
        end
        checks++;
        if (ERR_OVERRUN !== 1'b0 || ERR_TIMEOUT !== 1'b0) begin
            errors++; $display("FAIL rand_err_flags: got ovr=%b tmo=%b want 0 0", ERR_OVERRUN, ERR_TIMEOUT);
        end
        spurious = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overrun();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
